// File: rtl/rv_multicycle_core.sv
// Multicycle RV32I-subset core (lw/sw/addi/add/sub/and/or/slt/beq) with a single ready-based memory port.
// Define RV_MC_JAL_EN to add jal support; without it jal is treated as illegal.
module rv_multicycle_core #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          DBG_W    = 8
) (
    input  logic             clk,
    input  logic             rst,
    output logic             mem_req,
    output logic             mem_we,
    output logic [31:0]      mem_addr,
    output logic [31:0]      mem_wdata,
    input  logic [31:0]      mem_rdata,
    input  logic             mem_ready,
    input  logic [4:0]       dbg_sel,
    output logic [DBG_W-1:0] dbg_data,
    output logic [31:0]      pc_out,
    output logic [31:0]      instr_out,
    output logic [3:0]       state_out,
    output logic             halt
);
    localparam logic [3:0] S_FETCH  = 4'd0;
    localparam logic [3:0] S_DECODE = 4'd1;
    localparam logic [3:0] S_MEMADR = 4'd2;
    localparam logic [3:0] S_MEMRD  = 4'd3;
    localparam logic [3:0] S_MEMWR  = 4'd4;
    localparam logic [3:0] S_EXEC_R = 4'd5;
    localparam logic [3:0] S_EXEC_I = 4'd6;
    localparam logic [3:0] S_ALUWB  = 4'd7;
    localparam logic [3:0] S_BEQ    = 4'd8;
    localparam logic [3:0] S_HALT   = 4'd15;
`ifdef RV_MC_JAL_EN
    localparam logic [3:0] S_JAL    = 4'd9;
    localparam logic [6:0] OP_JAL   = 7'b1101111;
`endif
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_REG    = 7'b0110011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;

    logic [3:0]  state_q, state_d;
    logic [31:0] pc_q, pc_d, ir_q, ir_d, oldpc_q, oldpc_d;
    logic [31:0] a_q, a_d, b_q, b_d, aluout_q, aluout_d, tgt_q, tgt_d;
    logic [31:0] regs_q [32];
    logic        rfWe;
    logic [31:0] rfData;

    logic [6:0]  opcode, funct7;
    logic [2:0]  funct3;
    logic [4:0]  rd, rs1, rs2;
    logic [31:0] immI, immS, immB, rs1Val, rs2Val, aluR;
    logic        legalR;

    assign opcode = ir_q[6:0];
    assign rd     = ir_q[11:7];
    assign funct3 = ir_q[14:12];
    assign rs1    = ir_q[19:15];
    assign rs2    = ir_q[24:20];
    assign funct7 = ir_q[31:25];
    assign immI   = {{20{ir_q[31]}}, ir_q[31:20]};
    assign immS   = {{20{ir_q[31]}}, ir_q[31:25], ir_q[11:7]};
    assign immB   = {{19{ir_q[31]}}, ir_q[31], ir_q[7], ir_q[30:25], ir_q[11:8], 1'b0};
`ifdef RV_MC_JAL_EN
    logic [31:0] immJ;
    assign immJ   = {{11{ir_q[31]}}, ir_q[31], ir_q[19:12], ir_q[20], ir_q[30:21], 1'b0};
`endif

    assign rs1Val = (rs1 == 5'd0) ? 32'd0 : regs_q[rs1];
    assign rs2Val = (rs2 == 5'd0) ? 32'd0 : regs_q[rs2];

    always_comb begin
        legalR = 1'b0;
        aluR   = a_q + b_q;
        case ({funct7, funct3})
            {7'b0000000, 3'b000}: legalR = 1'b1;
            {7'b0100000, 3'b000}: begin legalR = 1'b1; aluR = a_q - b_q; end
            {7'b0000000, 3'b111}: begin legalR = 1'b1; aluR = a_q & b_q; end
            {7'b0000000, 3'b110}: begin legalR = 1'b1; aluR = a_q | b_q; end
            {7'b0000000, 3'b010}: begin
                legalR = 1'b1;
                aluR   = ($signed(a_q) < $signed(b_q)) ? 32'd1 : 32'd0;
            end
            default: ;
        endcase
    end

    // Load data is staged through ALUOUT and committed by ALUWB, giving lw its extra clock.
    always_comb begin
        state_d  = state_q;
        pc_d     = pc_q;
        ir_d     = ir_q;
        oldpc_d  = oldpc_q;
        a_d      = a_q;
        b_d      = b_q;
        aluout_d = aluout_q;
        tgt_d    = tgt_q;
        rfWe     = 1'b0;
        rfData   = aluout_q;
        case (state_q)
            S_FETCH: begin
                if (mem_ready) begin
                    ir_d    = mem_rdata;
                    oldpc_d = pc_q;
                    pc_d    = pc_q + 32'd4;
                    state_d = S_DECODE;
                end
            end
            S_DECODE: begin
                a_d     = rs1Val;
                b_d     = rs2Val;
                tgt_d   = oldpc_q + immB;
                state_d = S_HALT;
                case (opcode)
                    OP_LOAD:   if (funct3 == 3'b010) state_d = S_MEMADR;
                    OP_STORE:  if (funct3 == 3'b010) state_d = S_MEMADR;
                    OP_IMM:    if (funct3 == 3'b000) state_d = S_EXEC_I;
                    OP_REG:    if (legalR)           state_d = S_EXEC_R;
                    OP_BRANCH: if (funct3 == 3'b000) state_d = S_BEQ;
`ifdef RV_MC_JAL_EN
                    OP_JAL: begin
                        tgt_d   = oldpc_q + immJ;
                        state_d = S_JAL;
                    end
`endif
                    default: ;
                endcase
            end
            S_MEMADR: begin
                aluout_d = a_q + ((opcode == OP_STORE) ? immS : immI);
                state_d  = (opcode == OP_STORE) ? S_MEMWR : S_MEMRD;
            end
            S_MEMRD: begin
                if (mem_ready) begin
                    aluout_d = mem_rdata;
                    state_d  = S_ALUWB;
                end
            end
            S_MEMWR:  if (mem_ready) state_d = S_FETCH;
            S_EXEC_R: begin
                aluout_d = aluR;
                state_d  = S_ALUWB;
            end
            S_EXEC_I: begin
                aluout_d = a_q + immI;
                state_d  = S_ALUWB;
            end
            S_ALUWB: begin
                rfWe    = 1'b1;
                state_d = S_FETCH;
            end
            S_BEQ: begin
                if (a_q == b_q) pc_d = tgt_q;
                state_d = S_FETCH;
            end
`ifdef RV_MC_JAL_EN
            S_JAL: begin
                rfWe    = 1'b1;
                rfData  = oldpc_q + 32'd4;
                pc_d    = tgt_q;
                state_d = S_FETCH;
            end
`endif
            S_HALT:  ;
            default: state_d = S_HALT;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= S_FETCH;
            pc_q     <= RESET_PC;
            ir_q     <= '0;
            oldpc_q  <= '0;
            a_q      <= '0;
            b_q      <= '0;
            aluout_q <= '0;
            tgt_q    <= '0;
            for (int i = 0; i < 32; i++) regs_q[i] <= '0;
        end else begin
            state_q  <= state_d;
            pc_q     <= pc_d;
            ir_q     <= ir_d;
            oldpc_q  <= oldpc_d;
            a_q      <= a_d;
            b_q      <= b_d;
            aluout_q <= aluout_d;
            tgt_q    <= tgt_d;
            if (rfWe && (rd != 5'd0)) regs_q[rd] <= rfData;
        end
    end

    assign mem_req   = (state_q == S_FETCH) || (state_q == S_MEMRD) || (state_q == S_MEMWR);
    assign mem_we    = (state_q == S_MEMWR);
    assign mem_addr  = (state_q == S_FETCH) ? pc_q : aluout_q;
    assign mem_wdata = b_q;
    assign dbg_data  = (dbg_sel == 5'd0) ? '0 : regs_q[dbg_sel][DBG_W-1:0];
    assign pc_out    = pc_q;
    assign instr_out = ir_q;
    assign state_out = state_q;
    assign halt      = (state_q == S_HALT);
endmodule
